// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        SUB,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// Quotient/remainder/divisor registers with the restoring subtract step.
module div_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             shift,
    input  logic             sub_en,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH:0]   r_q;
    logic             dz_q;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    // Two guard bits so an underflow shows up as a set MSB rather than wrapping.
    assign diff   = {1'b0, r_q} - {2'b00, d_q};
    assign borrow = diff[WIDTH+1];

    always_ff @(posedge clk) begin
        if (srst) begin
            q_q  <= '0;
            r_q  <= '0;
            d_q  <= '0;
            dz_q <= 1'b0;
        end else if (load) begin
            d_q <= divisor;
            if (divisor == '0) begin
                dz_q <= 1'b1;
                q_q  <= '1;
                r_q  <= {1'b0, dividend};
            end else begin
                dz_q <= 1'b0;
                q_q  <= dividend;
                r_q  <= '0;
            end
        end else if (shift) begin
            {r_q, q_q} <= {r_q[WIDTH-1:0], q_q, 1'b0};
        end else if (sub_en) begin
            if (!borrow) begin
                r_q    <= diff[WIDTH:0];
                q_q[0] <= 1'b1;
            end else begin
                q_q[0] <= 1'b0;
            end
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q[WIDTH-1:0];
    assign div_zero  = dz_q;

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: FSM and iteration counter around div_datapath.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             load, shift, sub_en;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        shift   = 1'b0;
        sub_en  = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Run) state_d = LOAD;
            end
            LOAD: begin
                Busy    = 1'b1;
                load    = 1'b1;
                count_d = '0;
                state_d = (Divisor == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                Busy    = 1'b1;
                shift   = 1'b1;
                state_d = SUB;
            end
            SUB: begin
                Busy   = 1'b1;
                sub_en = 1'b1;
                if (count_q == LAST_ITER) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = SHIFT;
                end
            end
            DONE: begin
                Done = 1'b1;
                // Run must be released before another operation can start.
                if (!Run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (Clk),
        .srst      (Reset),
        .load      (load),
        .shift     (shift),
        .sub_en    (sub_en),
        .dividend  (Dividend),
        .divisor   (Divisor),
        .quotient  (Quotient),
        .remainder (Remainder),
        .div_zero  (DivByZero)
    );

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider against an arithmetic reference model.
module tb_restoring_divider;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Run = 1'b0;
    logic [W-1:0] Dividend = '0;
    logic [W-1:0] Divisor = '0;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivByZero;

    int checks = 0;
    int errors = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: plain integer division; divide by zero gives all-ones and echoes the dividend.
    function automatic void ref_div(input int dvd, input int dvs, output int q, output int r,
                                    output int lat);
        if (dvs == 0) begin
            q = 255; r = dvd; lat = 1;
        end else begin
            q = dvd / dvs; r = dvd % dvs; lat = 2 * W + 1;
        end
    endfunction

    // Starts one operation from IDLE and waits (bounded) for Done; returns the edge index it rose after.
    task automatic do_op(input int dvd, input int dvs, input bit hold, output int edges);
        int n;
        Dividend = W'(dvd);
        Divisor  = W'(dvs);
        Run      = 1'b1;
        tick();                  // edge 0
        if (!hold) Run = 1'b0;
        n = 0;
        while (Done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        edges = n;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Run   = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        checks++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got Q=%0d R=%0d Busy=%b Done=%b DBZ=%b, want all 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
        $display("reset: Q=%0d R=%0d Busy=%b Done=%b DBZ=%b", Quotient, Remainder, Busy, Done, DivByZero);
    endtask

    task automatic test_directed();
        int dvd_t[6] = '{100, 255, 5, 200, 42, 42};
        int dvs_t[6] = '{7, 1, 9, 200, 0, 6};
        int eq, er, el, lat;
        for (int i = 0; i < 6; i++) begin
            ref_div(dvd_t[i], dvs_t[i], eq, er, el);
            do_op(dvd_t[i], dvs_t[i], 1'b0, lat);
            $display("directed %0d/%0d: Q=%0d R=%0d DBZ=%b latency=%0d", dvd_t[i], dvs_t[i],
                     Quotient, Remainder, DivByZero, lat);
            checks++;
            if (Quotient !== W'(eq) || Remainder !== W'(er)) begin
                errors++;
                $display("FAIL directed_result %0d/%0d: got %0d r %0d, want %0d r %0d",
                         dvd_t[i], dvs_t[i], Quotient, Remainder, eq, er);
            end
            checks++;
            if (lat != el || Busy !== 1'b0 || DivByZero !== (dvs_t[i] == 0)) begin
                errors++;
                $display("FAIL directed_status %0d/%0d: got lat=%0d Busy=%b DBZ=%b, want lat=%0d Busy=0 DBZ=%b",
                         dvd_t[i], dvs_t[i], lat, Busy, DivByZero, el, dvs_t[i] == 0);
            end
            tick();              // Run already low: Done must last one cycle only
            checks++;
            if (Done !== 1'b0 || Quotient !== W'(eq) || Remainder !== W'(er)) begin
                errors++;
                $display("FAIL directed_idle %0d/%0d: got Done=%b Q=%0d R=%0d, want Done=0 Q=%0d R=%0d",
                         dvd_t[i], dvs_t[i], Done, Quotient, Remainder, eq, er);
            end
        end
    endtask

    task automatic test_run_hold();
        int lat;
        int bad;
        do_op(200, 3, 1'b1, lat);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (Done !== 1'b1 || Busy !== 1'b0 || Quotient !== 8'd66 || Remainder !== 8'd2) bad++;
        end
        $display("run_hold 200/3: Q=%0d R=%0d Done=%b after 10 held cycles", Quotient, Remainder, Done);
        checks++;
        if (bad != 0 || lat != 17) begin
            errors++;
            $display("FAIL run_hold_stable: got %0d unstable cycles lat=%0d, want 0 and 17", bad, lat);
        end
        Run = 1'b0;
        tick();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || Quotient !== 8'd66 || Remainder !== 8'd2) begin
            errors++;
            $display("FAIL run_release: got Done=%b Busy=%b Q=%0d R=%0d, want 0 0 66 2",
                     Done, Busy, Quotient, Remainder);
        end
        do_op(9, 4, 1'b1, lat);
        $display("run_hold restart 9/4: Q=%0d R=%0d latency=%0d", Quotient, Remainder, lat);
        checks++;
        if (Quotient !== 8'd2 || Remainder !== 8'd1 || lat != 17) begin
            errors++;
            $display("FAIL run_restart: got %0d r %0d lat=%0d, want 2 r 1 lat=17", Quotient, Remainder, lat);
        end
        Run = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        Dividend = 8'd100;
        Divisor  = 8'd7;
        Run      = 1'b1;
        tick();                  // edge 0
        Run = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        Reset = 1'b1;
        tick();                  // edge 8 samples Reset
        Reset = 1'b0;
        $display("reset_mid: Q=%0d R=%0d Busy=%b Done=%b DBZ=%b", Quotient, Remainder, Busy, Done, DivByZero);
        checks++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got Q=%0d R=%0d Busy=%b Done=%b DBZ=%b, want all 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: got Busy=%b Done=%b, want 0 0", Busy, Done);
        end
    endtask

    task automatic test_input_change();
        int n;
        Dividend = 8'd100;
        Divisor  = 8'd7;
        Run      = 1'b1;
        tick();                  // edge 0
        Run = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        Dividend = W'($urandom_range(0, 255));
        Divisor  = W'($urandom_range(0, 255));
        n = 5;
        while (Done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        $display("input_change 100/7: Q=%0d R=%0d latency=%0d", Quotient, Remainder, n);
        checks++;
        if (Quotient !== 8'd14 || Remainder !== 8'd2 || n != 17 || DivByZero !== 1'b0) begin
            errors++;
            $display("FAIL input_change: got %0d r %0d lat=%0d DBZ=%b, want 14 r 2 lat=17 DBZ=0",
                     Quotient, Remainder, n, DivByZero);
        end
        tick();
    endtask

    task automatic test_random();
        int dvd, dvs, eq, er, el, lat;
        bit hold;
        for (int i = 0; i < 1000; i++) begin
            dvd  = int'($urandom_range(0, 255));
            dvs  = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
            hold = 1'($urandom_range(0, 1));
            ref_div(dvd, dvs, eq, er, el);
            do_op(dvd, dvs, hold, lat);
            $display("random %0d: %0d/%0d -> Q=%0d R=%0d DBZ=%b latency=%0d", i, dvd, dvs,
                     Quotient, Remainder, DivByZero, lat);
            checks++;
            if (Quotient !== W'(eq) || Remainder !== W'(er) || lat != el ||
                DivByZero !== (dvs == 0)) begin
                errors++;
                $display("FAIL random %0d/%0d: got %0d r %0d lat=%0d DBZ=%b, want %0d r %0d lat=%0d DBZ=%b",
                         dvd, dvs, Quotient, Remainder, lat, DivByZero, eq, er, el, dvs == 0);
            end
            if (dvs != 0) begin
                checks++;
                if (int'(Quotient) * dvs + int'(Remainder) != dvd || int'(Remainder) >= dvs) begin
                    errors++;
                    $display("FAIL invariant %0d/%0d: got Q*D+R=%0d R=%0d, want %0d and R<D",
                             dvd, dvs, int'(Quotient) * dvs + int'(Remainder), Remainder, dvd);
                end
            end
            Run = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_run_hold();
        test_reset_mid();
        test_input_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
